// File: rtl/rv32_pkg.sv
// Shared types and constants for the AtomRV32I front end.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0: shown to decode whenever nothing is buffered.
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with a registered head entry, flush and occupancy.
// The head register always holds the oldest entry, so a write becomes visible
// on the output one cycle later and there is no write-to-read bypass.
module fetch_fifo #(
    parameter int unsigned      WIDTH       = 64,
    parameter int unsigned      DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             do_pop;

    assign empty  = (count_reg == '0);
    assign full   = (count_reg == CW'(DEPTH));
    assign count  = count_reg;
    assign dout   = dout_reg;
    assign do_pop = pop && !empty;

    // Entry storage; a flush discards the write issued in the same cycle.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    // Pointers and occupancy; push and pop together on a full FIFO keep the count.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(do_pop);
        end
    end

    // Head register: next oldest entry after a pop, or the incoming word when
    // it becomes the only entry. Holds its last value while empty or flushed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_reg <= RESET_VALUE;
        end else if (!flush) begin
            if (do_pop) begin
                if (count_reg > CW'(1)) begin
                    dout_reg <= mem_reg[rd_ptr_reg + AW'(1)];
                end else if (push) begin
                    dout_reg <= din;
                end
            end else if (empty && push) begin
                dout_reg <= din;
            end
        end
    end

    // Pushing into a full FIFO without a matching pop means the credit rule broke.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && full && !pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited word requests to
// instruction memory, buffers in-order responses with their PCs, and hands
// them to decode. A redirect flushes the buffer and drops in-flight responses.
module instr_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] PC_RESET   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    import rv32_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

    logic [XLEN-1:0]  pc_reg;
    logic [XLEN-1:0]  pc_next;
    logic [CNT_W-1:0] inflight_reg;
    logic [CNT_W-1:0] inflight_next;
    logic [CNT_W-1:0] drop_cnt_reg;
    logic [CNT_W-1:0] drop_cnt_next;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    fetch_entry_t     fifo_din;
    fetch_entry_t     fifo_dout;

    logic [CNT_W:0]   occupancy;
    logic             has_credit;
    logic             req_fire;
    logic             rsp_keep;
    logic             deq;

    // Credit: in-flight requests plus buffered entries never exceed the FIFO size,
    // so every response that is kept always finds a free slot.
    assign occupancy      = {1'b0, inflight_reg} + {1'b0, fifo_count};
    assign has_credit     = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
    assign imem_req_valid = rst_n && !redirect_valid && has_credit;
    assign imem_req_addr  = pc_reg & WORD_MASK;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses still owed to a pre-redirect stream are discarded, as is one
    // arriving in the redirect cycle itself.
    assign rsp_keep       = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;

    // With nothing to drop, every outstanding request belongs to the current
    // stream, so the oldest one sits inflight words behind the fetch PC.
    assign fifo_din.instr = imem_rsp_data;
    assign fifo_din.pc    = pc_reg - (XLEN'(inflight_reg) << 2);

    assign id_valid       = !fifo_empty && !redirect_valid;
    assign deq            = id_valid && id_ready;
    assign id_instr       = fifo_empty ? INSTR_NOP : fifo_dout.instr;
    assign id_pc          = fifo_dout.pc;

    fetch_fifo #(
        .WIDTH       ($bits(fetch_entry_t)),
        .DEPTH       (FIFO_DEPTH),
        .RESET_VALUE ({INSTR_NOP, PC_RESET})
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (rsp_keep),
        .din   (fifo_din),
        .pop   (deq),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next PC, in-flight and drop counts; a redirect turns every response
    // still outstanding after this cycle into one to be dropped.
    always_comb begin
        pc_next       = pc_reg;
        inflight_next = inflight_reg + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        drop_cnt_next = drop_cnt_reg;
        if (redirect_valid) begin
            pc_next       = redirect_pc & WORD_MASK;
            drop_cnt_next = inflight_reg - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_next = pc_reg + XLEN'(4);
            end
            if (imem_rsp_valid && (drop_cnt_reg != '0)) begin
                drop_cnt_next = drop_cnt_reg - CNT_W'(1);
            end
        end
    end

    // Fetch-state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg       <= PC_RESET;
            inflight_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            pc_reg       <= pc_next;
            inflight_reg <= inflight_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // A kept response must land in a free slot unless decode frees one this cycle.
    a_credit_holds: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_keep && fifo_full && !deq));

    // A response can only arrive for a request that is still outstanding.
    a_rsp_owed: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (inflight_reg == '0)));

endmodule
